mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified memory of the 16-bit MIPS core between the instruction-fetch port and the load/store (lw/sw) data port. It grants one requester at a time and drives a req/ack memory handshake. It returns read data with a one-cycle done pulse and aborts stuck accesses with a timeout error. It sits between the fetch/MEM stages, which are gated by the control unit's mem_read/mem_write, and the memory model.

## Interface
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ack (>=1)
- MAX_STARVE, 2, consecutive data grants allowed while fetch is pending (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address, stable while if_req
- if_rdata  out  DW  fetched word, valid with if_done
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  timeout flag, valid with if_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = sw write, 0 = lw read
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid with d_done on reads
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  timeout flag, valid with d_done
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ack
- mem_ack  in  1  access complete, sampled while mem_req=1

## Operation
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE: arbitrate using the sampled requests.
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both, starve_cnt < MAX_STARVE: grant data, starve_cnt++.
  - Both, starve_cnt == MAX_STARVE: grant fetch.
  - Any fetch grant clears starve_cnt. A data grant with if_req low also clears it.
  - On a grant: latch the owner, addr, we and wdata (we=0 for fetch), go to BUSY.
  - Neither request: stay in IDLE.
- BUSY: mem_req=1; mem_we, mem_addr, mem_wdata are held from the latched values.
  - The timeout counter tmo increments each BUSY cycle.
  - mem_ack=1: capture mem_rdata for reads, err=0, go to DONE.
  - tmo reaches TIMEOUT-1 without ack: err=1, captured data=0, go to DONE.
- DONE: mem_req=0.
  - Pulse the owner's done and err for exactly one cycle.
  - Update the owner's rdata on reads, including timed-out reads (to 0). Writes leave d_rdata unchanged.
  - Clear tmo and go to IDLE.
- rdata outputs hold their value between transactions.
- Requests arriving during BUSY/DONE wait; there is no queueing beyond req level.
- mem_ack outside BUSY is ignored.

## Timing
- Reset (async assert, any state): the following go to 0 immediately.
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - if_done, d_done, if_err, d_err = 0.
  - if_rdata, d_rdata = 0.
  - starve_cnt, tmo = 0.
- Reset mid-transaction: the access is dropped with no done pulse. The requester re-issues it after reset.
- Request sampled in IDLE at cycle 0:
  - mem_req rises in cycle 1.
  - Ack in cycle k (k>=1) gives done in cycle k+1, then IDLE in cycle k+2.
- Minimum latency is req to done = 2 cycles. Minimum back-to-back issue interval is 3 cycles.
- Timeout: mem_req is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT), then the error done pulse comes in cycle TIMEOUT+1.
- Ack in the same cycle as the final timeout cycle counts as success (ack wins).
- Requesters must deassert req, or present a new request, in the cycle after done. IDLE re-samples in that cycle.
- Simultaneous requests in IDLE resolve in the same cycle; there is no extra arbitration cycle.

## Test plan
- Single lw: d_req=1, d_we=0, d_addr=16'h0010, mem_ack=1 in cycle 1 with mem_rdata=16'hBEEF -> mem_req high in cycle 1 only; d_done=1 and d_rdata=16'hBEEF in cycle 2; d_err=0.
- Single sw: d_we=1, d_addr=16'h0020, d_wdata=16'h1234, ack in cycle 3 -> mem_we=1, mem_addr=16'h0020, mem_wdata=16'h1234 held in cycles 1-3; d_done in cycle 4; d_rdata unchanged.
- Starvation: if_req and d_req held continuously, MAX_STARVE=2, ack immediate -> grant order D, D, IF, D, D, IF; if_done every 9 cycles.
- Timeout: fetch with no ack, TIMEOUT=15 -> mem_req high in cycles 1-15; if_done=1, if_err=1, if_rdata=0 in cycle 16. Same run with ack in cycle 15 -> if_err=0.
- Reset mid-BUSY: assert reset_n=0 in cycle 2 of a data access -> mem_req=0 immediately, no d_done; after release, new if_req is served normally.
- Stray ack: mem_ack=1 while in IDLE and DONE -> no done pulse, no rdata change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory handshake seen by mem_port_arbiter.
// master is the arbiter's view and slave is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, if_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, if_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one req/ack memory, with bounded
// data-over-fetch priority and a per-access timeout that completes with an error.
module mem_port_arbiter_rsp #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          fire,
    input  logic          rd,
    input  logic          fail,
    input  logic [DW-1:0] data,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata
);
    // done/err are high only in the cycle after fire; rdata persists until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= fire;
            err  <= fire & fail;
            if (fire && rd)
                rdata <= data;
        end
    end
endmodule

module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int TIMEOUT    = 15,
    parameter int MAX_STARVE = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.master bus
);
    localparam int NUM_PORTS = 2;
    localparam int P_IF      = 0;
    localparam int P_D       = 1;
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int SW        = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic          owner;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t  state;
    req_t    cur;
    req_t    nxt;
    logic    mem_req_q;
    logic    mem_we_q;
    logic [TW-1:0] tmo;
    logic [SW-1:0] starve_cnt;

    logic [NUM_PORTS-1:0]         req;
    logic [NUM_PORTS-1:0][AW-1:0] addr;
    logic [NUM_PORTS-1:0]         fire;
    logic [NUM_PORTS-1:0]         done;
    logic [NUM_PORTS-1:0]         err;
    logic [NUM_PORTS-1:0][DW-1:0] rdata;

    logic          grant_d;
    logic          grant_if;
    logic          finish;
    logic          fail;
    logic [DW-1:0] rsp_data;

    assign req  = {bus.d_req,  bus.if_req};
    assign addr = {bus.d_addr, bus.if_addr};

    // Data wins unless fetch has already been passed over MAX_STARVE times in a row.
    assign grant_d  = req[P_D] & (~req[P_IF] | (starve_cnt < SW'(MAX_STARVE)));
    assign grant_if = req[P_IF] & ~grant_d;

    always_comb begin
        nxt       = '0;
        nxt.owner = grant_d;
        nxt.we    = grant_d & bus.d_we;
        nxt.addr  = addr[grant_d];
        nxt.wdata = grant_d ? bus.d_wdata : '0;
    end

    // Ack on the last allowed cycle still counts as success.
    assign fail     = ~bus.mem_ack;
    assign finish   = (state == BUSY) & (bus.mem_ack | (tmo == TW'(TIMEOUT - 1)));
    assign rsp_data = fail ? '0 : bus.mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            tmo        <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        cur       <= nxt;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= nxt.we;
                        tmo       <= '0;
                        state     <= BUSY;
                        if (grant_d && req[P_IF])
                            starve_cnt <= starve_cnt + 1'b1;
                        else
                            starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    tmo <= tmo + 1'b1;
                    if (finish) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    tmo   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign fire[p] = finish & (cur.owner == 1'(p));

        mem_port_arbiter_rsp #(.DW(DW)) u_rsp (
            .clk     (clk),
            .reset_n (reset_n),
            .fire    (fire[p]),
            .rd      (~cur.we),
            .fail    (fail),
            .data    (rsp_data),
            .done    (done[p]),
            .err     (err[p]),
            .rdata   (rdata[p])
        );
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = cur.addr;
    assign bus.mem_wdata = cur.wdata;

    assign bus.if_done  = done[P_IF];
    assign bus.if_err   = err[P_IF];
    assign bus.if_rdata = rdata[P_IF];
    assign bus.d_done   = done[P_D];
    assign bus.d_err    = err[P_D];
    assign bus.d_rdata  = rdata[P_D];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions are queued at issue time
// and a monitor pops and compares them on every done pulse.
module tb_mem_port_arbiter;
    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int          ack_at = 0;
    bit          stray = 1'b0;
    bit          rd_from_addr = 1'b0;
    logic [15:0] rd_val = 16'h0000;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(15), .MAX_STARVE(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit port, input bit err, input logic [15:0] rdata);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Memory model: counts mem_req cycles and acks on the ack_at-th one (0 = never).
    initial begin
        int bcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                bcnt++;
                bus.mem_ack   = (ack_at != 0) && (bcnt == ack_at);
                bus.mem_rdata = rd_from_addr ? bus.mem_addr + 16'h0001 : rd_val;
            end else begin
                bcnt = 0;
                bus.mem_ack   = stray;
                bus.mem_rdata = 16'hDEAD;
            end
        end
    end

    task automatic mon_port(input bit port, input logic err, input logic [15:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            chk(port ? "unexpected_d_done" : "unexpected_if_done", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("done_port", {31'd0, port}, {31'd0, e.port});
            chk(port ? "d_err" : "if_err", {31'd0, err}, {31'd0, e.err});
            chk(port ? "d_rdata" : "if_rdata", {16'd0, rdata}, {16'd0, e.rdata});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.if_done) mon_port(1'b0, bus.if_err, bus.if_rdata);
                if (bus.d_done)  mon_port(1'b1, bus.d_err, bus.d_rdata);
            end
        end
    end

    // Issues one request, pushes its expected completion and tracks the bus until done.
    task automatic run_txn(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int ack, input bit exp_err,
                           input logic [15:0] exp_rd, input int exp_high);
        int hi = 0;
        int dcyc = 0;
        step();
        ack_at = ack;
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        push(port, exp_err, exp_rd);
        for (int c = 1; c <= 60; c++) begin
            step();
            if (bus.mem_req) begin
                hi++;
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, we});
                chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
                if (we) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
            end
            if ((port && bus.d_done) || (!port && bus.if_done)) begin
                dcyc = c;
                break;
            end
        end
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        chk("done_cycle", dcyc, exp_high + 1);
        chk("mem_req_cycles", hi, exp_high);
    endtask

    initial begin
        int ifc, first, second;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        #1;
        chk("rst_mem_req", {31'd0, bus.mem_req}, 0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 0);
        chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 0);
        chk("rst_dones", {30'd0, bus.if_done, bus.d_done}, 0);
        chk("rst_errs", {30'd0, bus.if_err, bus.d_err}, 0);
        chk("rst_if_rdata", {16'd0, bus.if_rdata}, 0);
        chk("rst_d_rdata", {16'd0, bus.d_rdata}, 0);
        step(); step();
        reset_n = 1'b1;
        step();

        // lw, then sw leaving d_rdata alone
        rd_val = 16'hBEEF;
        run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b0, 16'hBEEF, 1);
        run_txn(1'b1, 1'b1, 16'h0020, 16'h1234, 3, 1'b0, 16'hBEEF, 3);

        // stray acks in IDLE and DONE
        stray = 1'b1;
        step(); step(); step();
        chk("stray_d_rdata", {16'd0, bus.d_rdata}, 16'hBEEF);
        rd_val = 16'h4321;
        run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 1, 1'b0, 16'h4321, 1);
        step(); step(); step();
        stray = 1'b0;
        chk("stray_d_rdata2", {16'd0, bus.d_rdata}, 16'h4321);
        chk("stray_if_rdata", {16'd0, bus.if_rdata}, 16'h0000);

        // fetch acked on the last allowed cycle, then a real timeout
        rd_val = 16'h5A5A;
        run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 15, 1'b0, 16'h5A5A, 15);
        run_txn(1'b0, 1'b0, 16'h0044, 16'h0000, 0, 1'b1, 16'h0000, 15);

        // both held: D, D, IF, D, D, IF
        step();
        rd_from_addr = 1'b1; ack_at = 1;
        bus.if_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_we = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        push(1, 0, 16'h0201); push(1, 0, 16'h0201); push(0, 0, 16'h0101);
        push(1, 0, 16'h0201); push(1, 0, 16'h0201); push(0, 0, 16'h0101);
        ifc = 0; first = 0; second = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (bus.if_done) begin
                ifc++;
                if (ifc == 1) first = c;
                else begin
                    second = c;
                    break;
                end
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        rd_from_addr = 1'b0;
        chk("first_if_done", first, 8);
        chk("if_done_period", second - first, 9);
        step(); step();

        // reset in the second BUSY cycle drops the access
        step();
        ack_at = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0060;
        step();
        step();
        chk("busy_mem_req", {31'd0, bus.mem_req}, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_busy_mem_req", {31'd0, bus.mem_req}, 0);
        chk("rst_busy_d_done", {31'd0, bus.d_done}, 0);
        chk("rst_busy_d_rdata", {16'd0, bus.d_rdata}, 0);
        chk("rst_busy_if_rdata", {16'd0, bus.if_rdata}, 0);
        bus.d_req = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
        rd_val = 16'h7777;
        run_txn(1'b0, 1'b0, 16'h0050, 16'h0000, 2, 1'b0, 16'h7777, 2);

        step(); step(); step();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
